// File: rtl/label_pkg.sv
// Shared types for the label merger: label width default, merge request, FSM states.
package label_pkg;
  localparam int DEF_LABEL_WIDTH = 8;
  localparam int BG_LABEL        = 0;

  typedef logic [DEF_LABEL_WIDTH-1:0] label_t;

  typedef struct packed {
    label_t a;
    label_t b;
  } merge_req_t;

  typedef enum logic [2:0] {
    IDLE,
    FIND_A,
    FIND_B,
    LINK,
    FLATTEN,
    DONE
  } merger_state_e;
endpackage

// File: rtl/label_merger_fifo.sv
// Synchronous merge-request FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module merge_fifo
  import label_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type req_t = merge_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty,
  output logic dropped
);
  localparam int AW = $clog2(DEPTH);

  req_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign dropped  = push && !do_push;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/label_merger.sv
// Label equivalence table: queued union-find merges, frame-end flatten, root lookups.
// Optional LABEL_MERGER_STATS_EN adds merge_count / max_chase per-frame statistics.
module label_merger
  import label_pkg::*;
#(
  parameter int LABEL_WIDTH      = DEF_LABEL_WIDTH,
  parameter int MERGE_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   last_in_frame,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_labels,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  output logic                   busy,
  output logic                   merge_overflow,
  output logic                   resolve_done,
  output logic [LABEL_WIDTH-1:0] label_count,
  input  logic [LABEL_WIDTH-1:0] lookup_label,
  output logic [LABEL_WIDTH-1:0] lookup_root
`ifdef LABEL_MERGER_STATS_EN
  ,
  output logic [15:0]            merge_count,
  output logic [7:0]             max_chase
`endif
);
  localparam int NUM_LABELS = 2**LABEL_WIDTH;

  typedef logic [LABEL_WIDTH-1:0] lbl_t;
  typedef struct packed {
    lbl_t a;
    lbl_t b;
  } req_t;

  merger_state_e state, state_nxt;
  lbl_t          parent [NUM_LABELS];
  lbl_t          ra, rb, idx, ra_nxt, rb_nxt, idx_nxt;
  lbl_t          par_ra, par_rb, par_idx, par_par_idx, link_hi, link_lo;
  logic          frame_end_pending;
  logic          alloc, link_wr, flat_wr, flat_last;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  req_t          fifo_in, fifo_out;

  assign alloc     = enable && new_label_valid && (state != FLATTEN);
  assign fifo_push = enable && merge_labels && (state != FLATTEN);
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fifo_in   = '{a: merge_a, b: merge_b};
  assign busy      = (state != IDLE) || !fifo_empty;

  merge_fifo #(
    .DEPTH (MERGE_FIFO_DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_drop)
  );

  assign par_ra      = parent[ra];
  assign par_rb      = parent[rb];
  assign par_idx     = parent[idx];
  assign par_par_idx = parent[par_idx];
  assign link_hi     = (ra > rb) ? ra : rb;
  assign link_lo     = (ra > rb) ? rb : ra;

  always_comb begin
    state_nxt = state;
    ra_nxt    = ra;
    rb_nxt    = rb;
    idx_nxt   = idx;
    link_wr   = 1'b0;
    flat_wr   = 1'b0;
    flat_last = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          ra_nxt    = fifo_out.a;
          rb_nxt    = fifo_out.b;
          state_nxt = FIND_A;
        end else if (frame_end_pending) begin
          idx_nxt   = lbl_t'(1);
          state_nxt = FLATTEN;
        end
      end
      FIND_A: begin
        if (par_ra != ra) ra_nxt = par_ra;
        else              state_nxt = FIND_B;
      end
      FIND_B: begin
        if (par_rb != rb) rb_nxt = par_rb;
        else              state_nxt = LINK;
      end
      LINK: begin
        link_wr   = (ra != rb);
        state_nxt = IDLE;
      end
      FLATTEN: begin
        // Ascending sweep: parent[parent[idx]] is already a root when idx is visited.
        if (label_count == '0) begin
          flat_last = 1'b1;
        end else begin
          flat_wr = 1'b1;
          if (idx == label_count) flat_last = 1'b1;
          else                    idx_nxt   = idx + 1'b1;
        end
        if (flat_last) state_nxt = DONE;
      end
      DONE: begin
        if (alloc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ra                <= '0;
      rb                <= '0;
      idx               <= '0;
      label_count       <= '0;
      frame_end_pending <= 1'b0;
      merge_overflow    <= 1'b0;
      resolve_done      <= 1'b0;
      lookup_root       <= '0;
    end else begin
      state        <= state_nxt;
      ra           <= ra_nxt;
      rb           <= rb_nxt;
      idx          <= idx_nxt;
      resolve_done <= flat_last;
      if (alloc)     label_count    <= new_label_value;
      if (fifo_drop) merge_overflow <= 1'b1;
      if (flat_last)                       frame_end_pending <= 1'b0;
      else if (enable && last_in_frame)    frame_end_pending <= 1'b1;
      if (lookup_label == lbl_t'(BG_LABEL) || lookup_label > label_count)
        lookup_root <= '0;
      else
        lookup_root <= parent[lookup_label];
    end
  end

  // Table is not reset; allocation re-initialises each entry before use.
  always_ff @(posedge clk) begin
    if (alloc)   parent[new_label_value] <= new_label_value;
    if (link_wr) parent[link_hi]         <= link_lo;
    if (flat_wr) parent[idx]             <= par_par_idx;
  end

`ifdef LABEL_MERGER_STATS_EN
  logic [7:0] chase_cnt;
  logic       new_frame;

  assign new_frame = alloc && ((state == DONE) || (new_label_value == lbl_t'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chase_cnt   <= '0;
      merge_count <= '0;
      max_chase   <= '0;
    end else begin
      if (state == IDLE)
        chase_cnt <= '0;
      else if ((state == FIND_A || state == FIND_B) && chase_cnt != 8'hFF)
        chase_cnt <= chase_cnt + 1'b1;
      if (new_frame) begin
        merge_count <= '0;
        max_chase   <= '0;
      end else if (state == LINK) begin
        if (link_wr && merge_count != 16'hFFFF) merge_count <= merge_count + 1'b1;
        if (chase_cnt > max_chase)              max_chase   <= chase_cnt;
      end
    end
  end
`endif

  logic unused;
  assign unused = fifo_full;
endmodule

// File: tb/tb_label_merger.sv
// Randomized self-checking bench for label_merger against a component-set reference model.
module tb_label_merger;
  localparam int LW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          last_in_frame = 1'b0;
  logic          new_label_valid = 1'b0;
  logic          merge_labels = 1'b0;
  logic [LW-1:0] new_label_value = '0;
  logic [LW-1:0] merge_a = '0;
  logic [LW-1:0] merge_b = '0;
  logic [LW-1:0] lookup_label = '0;
  logic          busy, merge_overflow, resolve_done;
  logic [LW-1:0] label_count, lookup_root;

  int n_cmp = 0;
  int n_bad = 0;
  int comp [256];
  int mdl_count = 0;

  always #5 clk = ~clk;

  label_merger #(.LABEL_WIDTH(LW), .MERGE_FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .last_in_frame   (last_in_frame),
    .new_label_valid (new_label_valid),
    .new_label_value (new_label_value),
    .merge_labels    (merge_labels),
    .merge_a         (merge_a),
    .merge_b         (merge_b),
    .busy            (busy),
    .merge_overflow  (merge_overflow),
    .resolve_done    (resolve_done),
    .label_count     (label_count),
    .lookup_label    (lookup_label),
    .lookup_root     (lookup_root)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: root of a label is the smallest label in its equivalence class.
  function automatic int mdl_root(input int l);
    int r;
    if (l == 0 || l > mdl_count) return 0;
    r = l;
    for (int i = 1; i <= mdl_count; i++)
      if (comp[i] == comp[l] && i < r) r = i;
    return r;
  endfunction

  task automatic mdl_union(input int a, input int b);
    int ca, cb;
    ca = comp[a];
    cb = comp[b];
    for (int i = 0; i < 256; i++)
      if (comp[i] == cb) comp[i] = ca;
  endtask

  task automatic alloc(input int v);
    if (v == 1) for (int i = 0; i < 256; i++) comp[i] = -i - 1;
    comp[v]   = v;
    mdl_count = v;
    enable = 1'b1; new_label_valid = 1'b1; new_label_value = v[LW-1:0];
    step();
    enable = 1'b0; new_label_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic merge(input int a, input int b, input bit drain);
    mdl_union(a, b);
    enable = 1'b1; merge_labels = 1'b1; merge_a = a[LW-1:0]; merge_b = b[LW-1:0];
    step();
    enable = 1'b0; merge_labels = 1'b0;
    if (drain) wait_idle("merge_drain");
  endtask

  task automatic frame_end(output int lat);
    int n;
    enable = 1'b1; last_in_frame = 1'b1;
    step();
    enable = 1'b0; last_in_frame = 1'b0;
    n = 0;
    while (!resolve_done && n < 1000) begin
      step();
      n++;
    end
    lat = n;
    chk("resolve_done", resolve_done, 1);
    step();
    chk("resolve_pulse", resolve_done, 0);
    chk("busy_in_done", busy, 1);
  endtask

  task automatic look(input int l);
    lookup_label = l[LW-1:0];
    step();
    chk($sformatf("lookup_%0d", l), lookup_root, mdl_root(l));
  endtask

  initial begin
    int lat, nl, nm, a, b, hits;

    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_overflow", merge_overflow, 0);
    chk("rst_resolve", resolve_done, 0);
    chk("rst_count", label_count, 0);
    chk("rst_root", lookup_root, 0);
    rst_n = 1'b1;
    step();

    // Empty frame: flatten exits without any table sweep.
    mdl_count = 0;
    frame_end(lat);
    chk("empty_latency", lat, 2);
    look(5);
    look(0);
    chk("empty_count", label_count, 0);

    for (int i = 1; i <= 3; i++) alloc(i);
    chk("count3", label_count, 3);
    merge(1, 3, 1);
    frame_end(lat);
    for (int i = 1; i <= 3; i++) look(i);

    for (int i = 1; i <= 4; i++) alloc(i);
    merge(3, 4, 1); merge(2, 3, 1); merge(1, 2, 1);
    frame_end(lat);
    for (int i = 1; i <= 4; i++) look(i);

    for (int i = 1; i <= 4; i++) alloc(i);
    merge(2, 4, 1); merge(3, 4, 1);
    frame_end(lat);
    for (int i = 1; i <= 4; i++) look(i);

    // Random frames; the last queues merges back to back straight into frame end.
    for (int f = 0; f < 5; f++) begin
      nl = $urandom_range(40, 5);
      nm = $urandom_range(nl, 0);
      for (int i = 1; i <= nl; i++) alloc(i);
      chk("rand_count", label_count, nl);
      for (int m = 0; m < nm; m++) begin
        a = $urandom_range(nl - 1, 1);
        b = $urandom_range(nl, a + 1);
        merge(a, b, (f != 4) || (m >= 3));
      end
      if (f == 4) begin
        merge(1, 2, 0); merge(nl - 1, nl, 0); merge(2, nl - 1, 0);
      end
      frame_end(lat);
      for (int i = 0; i <= nl + 2; i++) look(i);
    end

    // Deep chain so each chase is long, then flood the FIFO.
    for (int i = 1; i <= 16; i++) alloc(i);
    for (int i = 15; i >= 1; i--) merge(i, i + 1, 1);
    chk("no_overflow_yet", merge_overflow, 0);
    for (int k = 0; k < DEPTH + 2; k++) merge(15, 16, 0);
    chk("overflow_set", merge_overflow, 1);
    chk("busy_flood", busy, 1);
    wait_idle("flood_drain");
    chk("overflow_sticky", merge_overflow, 1);
    frame_end(lat);
    for (int i = 1; i <= 16; i++) look(i);

    // Reset in the middle of a long flatten.
    for (int i = 1; i <= 200; i++) alloc(i);
    enable = 1'b1; last_in_frame = 1'b1;
    step();
    enable = 1'b0; last_in_frame = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("flatten_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", label_count, 0);
    chk("midrst_resolve", resolve_done, 0);
    chk("midrst_overflow", merge_overflow, 0);
    step();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (resolve_done) hits++;
    end
    chk("no_resolve_after_rst", hits, 0);
    for (int i = 1; i <= 6; i++) alloc(i);
    merge(2, 5, 1); merge(1, 4, 1); merge(4, 6, 1);
    frame_end(lat);
    for (int i = 0; i <= 7; i++) look(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
